// File: rtl/ysyx_25060170_regfile.sv
// ysyx_25060170_regfile
// General-purpose register file for the NPC core. Writebacks arrive through
// a valid/ready handshake. Two combinational read ports serve decode, with
// same-cycle write bypass. A per-register pending-write scoreboard lets
// decode stall on RAW hazards. After every reset, a clear sweep zeroes the
// array before any writeback is accepted.
module ysyx_25060170_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  mark_valid_i,
  input  logic [ADDR_WIDTH-1:0] mark_addr_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                state;
  state_t                state_nxt;

  // The counter is one bit wider than an index, so the carry out of the
  // increment marks the final sweep write without any wrap compare.
  logic [ADDR_WIDTH:0]   sweep_cnt;
  logic [ADDR_WIDTH:0]   sweep_inc;
  logic                  sweep_done;

  logic [DATA_WIDTH-1:0] mem [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;

  logic                  run;
  logic                  fire;
  logic                  wr_en;
  logic                  retire_en;
  logic                  mark_en;

  // Sweep progress: the carry out of the increment flags the last entry.
  always_comb begin
    sweep_inc  = sweep_cnt + (ADDR_WIDTH + 1)'(1);
    sweep_done = sweep_inc[ADDR_WIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT once the last entry has been cleared.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (sweep_done) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // Handshake and qualified write/retire/mark strobes. Ready comes only from
  // registered state.
  always_comb begin
    run        = (state == S_RUN);
    wb_ready_o = run;
    fire       = wb_valid_i & wb_ready_o;
    wr_en      = fire & wb_en_i & (wb_addr_i != '0);
    retire_en  = fire & (wb_addr_i != '0);
    mark_en    = run & mark_valid_i & (mark_addr_i != '0);
  end

  // Sweep counter: restarts from zero on every reset and holds once RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if (state == S_INIT) begin
      sweep_cnt <= sweep_inc;
    end
  end

  // Storage: the sweep writes zeros in INIT; writebacks land in RUN.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[sweep_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_en) begin
      mem[wb_addr_i] <= wb_data_i;
    end
  end

  // Scoreboard update.
  // The retire is applied before the mark, so the mark wins when both hit the
  // same address. A flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (state == S_INIT) begin
      busy_nxt = sweep_done ? '0 : '1;
    end else if (flush_i) begin
      busy_nxt = '0;
    end else begin
      if (retire_en) busy_nxt[wb_addr_i] = 1'b0;
      if (mark_en) busy_nxt[mark_addr_i] = 1'b1;
      busy_nxt[0] = 1'b0;
    end
  end

  // Scoreboard register: every entry reads busy while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '1;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read port 1: x0 is hardwired, with write bypass and retire bypass.
  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b1;
    if (run) begin
      if (rs1_addr_i == '0) begin
        rs1_busy_o = 1'b0;
      end else begin
        rs1_data_o = (wr_en && (wb_addr_i == rs1_addr_i)) ? wb_data_i : mem[rs1_addr_i];
        if (fire && (wb_addr_i == rs1_addr_i) &&
            !(mark_valid_i && (mark_addr_i == rs1_addr_i))) begin
          rs1_busy_o = 1'b0;
        end else begin
          rs1_busy_o = busy[rs1_addr_i];
        end
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rs2_data_o = '0;
    rs2_busy_o = 1'b1;
    if (run) begin
      if (rs2_addr_i == '0) begin
        rs2_busy_o = 1'b0;
      end else begin
        rs2_data_o = (wr_en && (wb_addr_i == rs2_addr_i)) ? wb_data_i : mem[rs2_addr_i];
        if (fire && (wb_addr_i == rs2_addr_i) &&
            !(mark_valid_i && (mark_addr_i == rs2_addr_i))) begin
          rs2_busy_o = 1'b0;
        end else begin
          rs2_busy_o = busy[rs2_addr_i];
        end
      end
    end
  end

endmodule
